// File: rtl/spi_pkg.sv
// Shared constants, FSM state type and small helpers for the SPI slave receiver.
package spi_pkg;

    // Default frame length in bits.
    localparam int DATA_W_DEF      = 16;

    // Default number of synchronizer flops on each SPI input (must be >= 2).
    localparam int SYNC_STAGES_DEF = 2;

    // Width of the received-bit counter; must hold the value DATA_W.
    localparam int BIT_CNT_W       = 5;

    // Receiver frame state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } spi_state_e;

    // Advance the bit counter by one.
    function automatic logic [BIT_CNT_W-1:0] bit_cnt_inc(input logic [BIT_CNT_W-1:0] cnt);
        return cnt + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by a delay flop
// so that rising and falling transitions of the synchronized level can be
// reported as single-cycle pulses.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchronizer chain plus one delay flop on its last stage
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver. Oversamples chip select, SPI clock and MOSI in the
// system clock domain, deserializes MSB-first frames into a parallel word that
// is offered through a valid/ready handshake, and shifts a response word back
// out on MISO (master_data).
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs_l,
    input  logic                 spi_clk,
    input  logic                 spi_data,
    output logic                 master_data,
    input  logic [DATA_W-1:0]    tx_data,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 overrun,
    output logic                 frame_err
);

    // Synchronized SPI inputs and their edge pulses
    logic                   sclk_level_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   cs_level_s;
    logic                   cs_rise_s;
    logic                   cs_fall_s;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   data_sync_s;
    logic                   unused_level_s;

    // Frame state and shift registers
    spi_state_e             state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [DATA_W-2:0]      rx_shift_q;
    logic [DATA_W-2:0]      tx_shift_q;
    logic [DATA_W-2:0]      tx_shift_d;
    logic                   miso_q;
    logic                   frame_err_q;

    // Consumer-facing word register
    logic [DATA_W-1:0]      rx_data_q;
    logic                   rx_valid_q;
    logic                   overrun_q;

    // Completed word and the strobe marking its final bit
    logic [DATA_W-1:0]      word_s;
    logic                   word_done_s;

    // The SPI clock idles low, so its synchronizer resets to 0.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .din_i   (spi_clk),
        .level_o (sclk_level_s),
        .rise_o  (sclk_rise_s),
        .fall_o  (sclk_fall_s)
    );

    // Chip select is active low, so its synchronizer resets to the deselected level.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .reset   (reset),
        .din_i   (spi_cs_l),
        .level_o (cs_level_s),
        .rise_o  (cs_rise_s),
        .fall_o  (cs_fall_s)
    );

    // Only the edge pulses drive the FSM; the levels are kept for debug visibility.
    assign unused_level_s = sclk_level_s ^ cs_level_s;

    // MOSI synchronizer with the same depth as the clock path so the sampled
    // bit lines up with the detected clock rise
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], spi_data};
        end
    end

    assign data_sync_s = data_sync_q[SYNC_STAGES-1];

    // The incoming word as it stands once the current bit is shifted in.
    assign word_s      = {rx_shift_q, data_sync_s};

    // The last bit of a frame lands: SHIFT, clock rise, no deselect this cycle.
    assign word_done_s = (state_q == SHIFT) && !cs_rise_s && sclk_rise_s &&
                         (bit_cnt_q == BIT_CNT_W'(DATA_W - 1));

    // Response shifter moves one bit towards MISO, zero filling behind.
    assign tx_shift_d  = {tx_shift_q[DATA_W-3:0], 1'b0};

    // Frame FSM: bit counting, receive/transmit shifting, MISO and frame error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= {BIT_CNT_W{1'b0}};
            rx_shift_q  <= {(DATA_W-1){1'b0}};
            tx_shift_q  <= {(DATA_W-1){1'b0}};
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall_s) begin
                        // MISO register holds the current bit, tx_shift_q the rest.
                        state_q    <= SHIFT;
                        bit_cnt_q  <= {BIT_CNT_W{1'b0}};
                        miso_q     <= tx_data[DATA_W-1];
                        tx_shift_q <= tx_data[DATA_W-2:0];
                    end else begin
                        state_q    <= IDLE;
                        miso_q     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise_s) begin
                        // Deselect mid-frame drops the partial word; an empty frame is silent.
                        state_q     <= IDLE;
                        bit_cnt_q   <= {BIT_CNT_W{1'b0}};
                        miso_q      <= 1'b0;
                        frame_err_q <= (bit_cnt_q != {BIT_CNT_W{1'b0}});
                    end else if (sclk_rise_s) begin
                        rx_shift_q <= word_s[DATA_W-2:0];
                        bit_cnt_q  <= bit_cnt_inc(bit_cnt_q);
                        if (word_done_s) begin
                            state_q <= WAIT_CS;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end else if (sclk_fall_s) begin
                        miso_q     <= tx_shift_q[DATA_W-2];
                        tx_shift_q <= tx_shift_d;
                    end else begin
                        state_q    <= SHIFT;
                    end
                end
                WAIT_CS: begin
                    // Extra SPI clocks are ignored until the master deselects.
                    if (cs_rise_s) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= {BIT_CNT_W{1'b0}};
                        miso_q    <= 1'b0;
                    end else begin
                        state_q   <= WAIT_CS;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bit_cnt_q <= {BIT_CNT_W{1'b0}};
                    miso_q    <= 1'b0;
                end
            endcase
        end
    end

    // Word offer and consumer handshake; a full holding register drops the new word
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q  <= {DATA_W{1'b0}};
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (word_done_s && (!rx_valid_q || rx_ready)) begin
                rx_data_q  <= word_s;
                rx_valid_q <= 1'b1;
            end else if (word_done_s) begin
                overrun_q  <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end else begin
                rx_valid_q <= rx_valid_q;
            end
        end
    end

    assign master_data = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign bit_cnt     = bit_cnt_q;
    assign overrun     = overrun_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: table of directed frames, hand-written corner cases
// and randomized frames checked against a queue-based reference model.
module tb_spi_slave_rx;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_cs_l;
    logic          spi_clk;
    logic          spi_data;
    logic          master_data;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [4:0]    bit_cnt;
    logic          overrun;
    logic          frame_err;

    int checks   = 0;
    int errors   = 0;
    int ovr_cnt  = 0;
    int ferr_cnt = 0;
    logic [DW-1:0] acc_q[$];

    typedef struct {
        logic [DW-1:0] mosi;
        int            nbits;
        logic [DW-1:0] tx;
        logic          ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        int            exp_ovr;
        int            exp_ferr;
        int            exp_acc;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    spi_slave_rx dut (
        .clk         (clk),
        .reset       (reset),
        .spi_cs_l    (spi_cs_l),
        .spi_clk     (spi_clk),
        .spi_data    (spi_data),
        .master_data (master_data),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .bit_cnt     (bit_cnt),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    // Consumer-side observation: accepted words and pulse cycles
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            if (overrun) ovr_cnt++;
            if (frame_err) ferr_cnt++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n clocks; inputs change 2 ns after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Master side of one frame: each phase lasts 4 clocks, MISO captured just
    // before each SPI clock rise.
    task automatic send_frame(input logic [DW-1:0] mosi, input int nbits, input logic [DW-1:0] tx,
                              input bit raise_cs, input bit ready_pulse,
                              output logic [DW-1:0] miso_bits, output logic [4:0] cnt_seen);
        tx_data   = tx;
        spi_cs_l  = 1'b0;
        miso_bits = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_data = mosi[DW-1-i];
            step(4);
            miso_bits = {miso_bits[DW-2:0], master_data};
            spi_clk   = 1'b1;
            if (ready_pulse && (i == nbits - 1)) begin
                step(2);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
                step(1);
            end else begin
                step(4);
            end
            spi_clk = 1'b0;
        end
        step(4);
        cnt_seen = bit_cnt;
        spi_data = 1'b0;
        if (raise_cs) begin
            spi_cs_l = 1'b1;
            step(6);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rx_data"},     rx_data,     32'h0);
        check({tag, " rx_valid"},    rx_valid,    32'h0);
        check({tag, " bit_cnt"},     bit_cnt,     32'h0);
        check({tag, " master_data"}, master_data, 32'h0);
        check({tag, " overrun"},     overrun,     32'h0);
        check({tag, " frame_err"},   frame_err,   32'h0);
    endtask

    task automatic apply_row(input int idx);
        vec_t          v;
        logic [DW-1:0] mb;
        logic [DW-1:0] exp_m;
        logic [DW-1:0] last_w;
        logic [4:0]    cs;
        int            ob, fb, ab;
        v  = vecs[idx];
        ob = ovr_cnt;
        fb = ferr_cnt;
        ab = acc_q.size();
        rx_ready = v.ready;
        send_frame(v.mosi, v.nbits, v.tx, 1'b1, 1'b0, mb, cs);
        exp_m = (v.nbits == 0) ? '0 : (v.tx >> (DW - v.nbits));
        check($sformatf("row%0d bit_cnt_before_cs", idx), cs, v.nbits);
        check($sformatf("row%0d miso", idx), mb, exp_m);
        check($sformatf("row%0d bit_cnt_after_cs", idx), bit_cnt, 32'h0);
        check($sformatf("row%0d rx_valid", idx), rx_valid, v.exp_valid);
        check($sformatf("row%0d rx_data", idx), rx_data, v.exp_data);
        check($sformatf("row%0d overrun_cycles", idx), ovr_cnt - ob, v.exp_ovr);
        check($sformatf("row%0d frame_err_cycles", idx), ferr_cnt - fb, v.exp_ferr);
        check($sformatf("row%0d accepted_words", idx), acc_q.size() - ab, v.exp_acc);
        if (v.exp_acc == 1) begin
            last_w = (acc_q.size() > ab) ? acc_q[acc_q.size()-1] : 'x;
            check($sformatf("row%0d accepted_value", idx), last_w, v.mosi);
        end
    endtask

    initial begin
        logic [DW-1:0] mb;
        logic [DW-1:0] exp_m;
        logic [DW-1:0] mosi;
        logic [DW-1:0] tx;
        logic [DW-1:0] exp_q[$];
        logic [4:0]    cs;
        int            ob, fb, ab, nb, exp_ferr;

        //            mosi      nb  tx        rdy   vld   data      ovr ferr acc
        vecs[0] = '{16'hA569, 16, 16'h3425, 1'b1, 1'b0, 16'hA569, 0, 0, 1};
        vecs[1] = '{16'h2563, 16, 16'h5A5A, 1'b1, 1'b0, 16'h2563, 0, 0, 1};
        vecs[2] = '{16'h9B63, 16, 16'h0F0F, 1'b1, 1'b0, 16'h9B63, 0, 0, 1};
        vecs[3] = '{16'h9B63, 16, 16'hFFFF, 1'b0, 1'b1, 16'h9B63, 0, 0, 0};
        vecs[4] = '{16'h6A61, 16, 16'h8001, 1'b0, 1'b1, 16'h9B63, 1, 0, 0};
        vecs[5] = '{16'h1234,  7, 16'hC3C3, 1'b0, 1'b1, 16'h9B63, 0, 1, 0};
        vecs[6] = '{16'h0001, 16, 16'h0000, 1'b1, 1'b0, 16'h0001, 0, 0, 1};
        vecs[7] = '{16'hFFFF,  0, 16'hAAAA, 1'b1, 1'b0, 16'h0001, 0, 0, 0};
        vecs[8] = '{16'hA569, 16, 16'h7E81, 1'b1, 1'b0, 16'hA569, 0, 0, 1};
        vecs[9] = '{16'h8000,  1, 16'h8000, 1'b1, 1'b0, 16'hA569, 0, 1, 0};

        reset    = 1'b1;
        spi_cs_l = 1'b1;
        spi_clk  = 1'b0;
        spi_data = 1'b0;
        rx_ready = 1'b0;
        tx_data  = '0;
        step(3);
        check_reset_values("reset");
        reset = 1'b0;
        step(4);

        // Basic, back-to-back, overrun and aborted frames
        for (int i = 0; i < 6; i++) apply_row(i);

        // Releasing the consumer drains the held word on the next cycle
        ab = acc_q.size();
        rx_ready = 1'b1;
        @(negedge clk);
        check("release rx_valid_same_cycle", rx_valid, 32'h1);
        @(negedge clk);
        check("release rx_valid_next_cycle", rx_valid, 32'h0);
        check("release accepted_value", (acc_q.size() > ab) ? acc_q[ab] : 16'hxxxx, 16'h9B63);
        @(posedge clk);
        #2;

        for (int i = 6; i < 8; i++) apply_row(i);

        // Consumer accepts on the same cycle the next word completes
        rx_ready = 1'b0;
        send_frame(16'h5AC3, 16, 16'h1111, 1'b1, 1'b0, mb, cs);
        check("simul first rx_valid", rx_valid, 32'h1);
        ob = ovr_cnt;
        ab = acc_q.size();
        send_frame(16'hC35A, 16, 16'h2222, 1'b1, 1'b1, mb, cs);
        check("simul rx_valid", rx_valid, 32'h1);
        check("simul rx_data", rx_data, 16'hC35A);
        check("simul overrun_cycles", ovr_cnt - ob, 32'h0);
        check("simul accepted_words", acc_q.size() - ab, 32'h1);
        check("simul accepted_value", (acc_q.size() > ab) ? acc_q[ab] : 16'hxxxx, 16'h5AC3);
        rx_ready = 1'b1;
        step(3);
        check("simul drain rx_valid", rx_valid, 32'h0);

        // Reset in the middle of a frame
        fb = ferr_cnt;
        send_frame(16'hFFFF, 9, 16'hFFFF, 1'b0, 1'b0, mb, cs);
        check("midreset bit_cnt_before", cs, 32'h9);
        check("midreset master_data_before", master_data, 32'h1);
        reset = 1'b1;
        step(1);
        check_reset_values("midreset");
        reset = 1'b0;
        step(1);
        spi_cs_l = 1'b1;
        step(8);
        check("midreset frame_err_cycles", ferr_cnt - fb, 32'h0);
        check("midreset bit_cnt_after", bit_cnt, 32'h0);
        apply_row(8);
        apply_row(9);

        // Randomized frames against a queue-based model; consumer always ready
        rx_ready = 1'b1;
        exp_q.delete();
        exp_ferr = 0;
        ob = ovr_cnt;
        fb = ferr_cnt;
        ab = acc_q.size();
        for (int n = 0; n < 25; n++) begin
            mosi = DW'($urandom);
            tx   = DW'($urandom);
            nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : DW;
            send_frame(mosi, nb, tx, 1'b1, 1'b0, mb, cs);
            exp_m = (nb == 0) ? '0 : (tx >> (DW - nb));
            check($sformatf("rand%0d miso", n), mb, exp_m);
            check($sformatf("rand%0d bit_cnt", n), cs, nb);
            if (nb == DW) exp_q.push_back(mosi);
            if (nb > 0 && nb < DW) exp_ferr++;
            step($urandom_range(0, 5));
        end
        check("rand accepted_words", acc_q.size() - ab, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("rand word%0d", k),
                  (acc_q.size() > ab + k) ? acc_q[ab + k] : 16'hxxxx, exp_q[k]);
        end
        check("rand frame_err_cycles", ferr_cnt - fb, exp_ferr);
        check("rand overrun_cycles", ovr_cnt - ob, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Downstream receiver for the 16-bit SPI master (`spi_2`). Oversamples `spi_cs_l`, `spi_clk` and `spi_data` in the system clock domain and deserializes each 16-bit MSB-first frame into a parallel word. Delivers the word through a valid/ready handshake. Shifts a response word back to the master on `master_data`.

## Interface

Parameters:
- `DATA_W`, 16: frame length in bits.
- `SYNC_STAGES`, 2: synchronizer flops on each SPI input; minimum 2.

Ports:
- `clk`, input, 1: system clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high.
- `spi_cs_l`, input, 1: chip select from master, active low.
- `spi_clk`, input, 1: SPI clock from master; idle low.
- `spi_data`, input, 1: serial data from master (MOSI).
- `master_data`, output, 1: serial response to master (MISO).
- `tx_data`, input, DATA_W: response word, captured at frame start.
- `rx_data`, output, DATA_W: last received word.
- `rx_valid`, output, 1: `rx_data` holds an unconsumed word.
- `rx_ready`, input, 1: consumer accepts `rx_data` when high with `rx_valid`.
- `bit_cnt`, output, 5: bits received in current frame, 0..16.
- `overrun`, output, 1: one-cycle pulse; completed word dropped.
- `frame_err`, output, 1: one-cycle pulse; CS rose mid-frame.

## Operation

- **SPI mode:** mode 0. Sample `spi_data` on synchronized `spi_clk` rising edge. Update `master_data` on falling edge.
- **Edge detection:** on the last synchronizer stage vs. one delay flop for `spi_clk` and `spi_cs_l`. `spi_data` is synchronized with the same depth, so data and clock stay aligned.
- **States:**
  - IDLE: CS high.
    - CS falling → SHIFT; `bit_cnt`=0; tx shift reg ← `tx_data`.
  - SHIFT: each clk rising edge shifts the rx shift reg left, LSB ← data, `bit_cnt`+1.
    - On the edge making `bit_cnt`=16 → WAIT_CS and the word is offered (below).
    - CS rising with `bit_cnt` in 1..15 → IDLE, `frame_err` pulse, partial word discarded.
    - CS rising with `bit_cnt`=0 → IDLE silently.
  - WAIT_CS: further `spi_clk` edges ignored; `bit_cnt` holds 16.
    - CS rising → IDLE, `bit_cnt` ← 0.
- **Word offer:**
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle: `rx_data` ← word, `rx_valid` ← 1.
  - If `rx_valid`=1 and `rx_ready`=0: word dropped, `rx_data` unchanged, `overrun` pulses.
- **Handshake:** `rx_valid` clears on the cycle after `rx_valid & rx_ready` unless a new word loads that same cycle. `rx_data` is stable while `rx_valid`=1.
- **MISO:**
  - `master_data` = tx shift reg MSB while not IDLE.
  - Each `spi_clk` falling edge in SHIFT shifts the tx reg left, zero fill.
  - `master_data` is 0 in IDLE.
- **Reset:** outputs and state return to reset values on the next `clk` edge, including mid-frame. No pulse is generated for the aborted frame.

## Timing

- **Reset values:** `rx_data`=0, `rx_valid`=0, `bit_cnt`=0, `master_data`=0, `overrun`=0, `frame_err`=0, state IDLE, synchronizers 0 except CS chain = 1.
- **Input-to-update latency:** a raw SPI edge is acted on at the `SYNC_STAGES`+1th `clk` rising edge after it (setup met). `rx_valid` rises on that edge for the 16th `spi_clk` rise.
- **SPI clock limit:** `spi_clk` high and low phases each ≥ 2 `clk` periods. CS setup to first `spi_clk` rise ≥ 2 `clk` periods.
- **First MISO bit:** valid `SYNC_STAGES`+1 clocks after CS fall, before the first sample edge.
- **Pulses:** `overrun` and `frame_err` are exactly one `clk` wide.

## Structure

- **Package `spi_pkg`:** `DATA_W` default constant, state enum (`IDLE`, `SHIFT`, `WAIT_CS`), bit-count width constant (5).
- **Sub-module `spi_sync_edge`:** parameter `SYNC_STAGES`, reset value; outputs synchronized level plus rise/fall pulses. Instantiated for `spi_clk` and `spi_cs_l`. `spi_data` uses a bare synchronizer chain of equal depth.

## Test plan

- **Basic frame:** master sends 16'hA569, `rx_ready`=1, `tx_data`=16'h3425 → `rx_data`=16'hA569, `rx_valid` one cycle; MISO bit stream 16'h3425 MSB first; `bit_cnt` 0→16→0.
- **Back-to-back:** frames 16'h2563 then 16'h9B63 with `rx_ready`=1 → two words in order, no `overrun`.
- **Overrun:** `rx_ready`=0, frames 16'h9B63 then 16'h6A61 → `rx_data` stays 16'h9B63, `overrun` pulses once after the second frame. `rx_ready`=1 → `rx_valid` falls next cycle.
- **Simultaneous accept and completion:** `rx_ready` rises the same cycle the 16th bit lands → new word loads, `rx_valid` stays 1, no `overrun`.
- **Aborted frame:** CS rises after 7 bits → `frame_err` pulse, `rx_valid` unchanged. Next full frame 16'h0001 received correctly.
- **Mid-frame reset:** assert `reset` after 9 bits → all outputs at reset values next edge. Following frame 16'hA569 received intact.
